// File: rtl/enemy_collision_pkg.sv
// Shared types and defaults for the enemy collision / dodge detector.
package enemy_collision_pkg;

   localparam int unsigned NUM_SHOTS = 3;
   localparam int unsigned COORD_W   = 11;
   localparam int unsigned ZONE_W    = 13;
   localparam int unsigned COOL_W    = 6;

   localparam int ENEMY_W_DEF         = 32;
   localparam int ENEMY_H_DEF         = 32;
   localparam int DODGE_MARGIN_DEF    = 16;
   localparam int DODGE_LOOKAHEAD_DEF = 64;
   localparam int DODGE_WAIT_DEF      = 35;

   typedef enum logic [1:0] {
      S_SCAN   = 2'd0,
      S_REPORT = 2'd1,
      S_DEAD   = 2'd2
   } state_t;

endpackage

// File: rtl/enemy_collision_detect_dodge_zone.sv
// Combinational test of whether the scan pixel lies in the dodge zone below the enemy.
module dodge_zone
   import enemy_collision_pkg::*;
#(
   parameter int ENEMY_W         = ENEMY_W_DEF,
   parameter int ENEMY_H         = ENEMY_H_DEF,
   parameter int DODGE_MARGIN    = DODGE_MARGIN_DEF,
   parameter int DODGE_LOOKAHEAD = DODGE_LOOKAHEAD_DEF
) (
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic [COORD_W-1:0] enemyTopLeftX,
   input  logic [COORD_W-1:0] enemyTopLeftY,
   output logic               inZone
);

   localparam logic signed [ZONE_W-1:0] MARGIN_S = ZONE_W'(DODGE_MARGIN);
   localparam logic signed [ZONE_W-1:0] RIGHT_S  = ZONE_W'(ENEMY_W - 1 + DODGE_MARGIN);
   localparam logic signed [ZONE_W-1:0] TOP_S    = ZONE_W'(ENEMY_H);
   localparam logic signed [ZONE_W-1:0] BOTTOM_S = ZONE_W'(ENEMY_H + DODGE_LOOKAHEAD - 1);

   logic signed [ZONE_W-1:0] px, py, ex, ey;
   logic signed [ZONE_W-1:0] xLoRaw, xLo, xHi, yLo, yHi;

   always_comb begin
      px = $signed({2'b00, pixelX});
      py = $signed({2'b00, pixelY});
      ex = $signed({2'b00, enemyTopLeftX});
      ey = $signed({2'b00, enemyTopLeftY});
      // Left bound may go negative near the screen edge; pin it to column 0.
      xLoRaw = ex - MARGIN_S;
      xLo    = xLoRaw[ZONE_W-1] ? '0 : xLoRaw;
      xHi    = ex + RIGHT_S;
      yLo    = ey + TOP_S;
      yHi    = ey + BOTTOM_S;
      inZone = (px >= xLo) && (px <= xHi) && (py >= yLo) && (py <= yHi);
   end

endmodule

// File: rtl/enemy_collision_detect.sv
// Per-frame enemy collision accumulation with a one-cycle report after each frame start.
module enemy_collision_detect
   import enemy_collision_pkg::*;
#(
   parameter int ENEMY_W         = ENEMY_W_DEF,
   parameter int ENEMY_H         = ENEMY_H_DEF,
   parameter int DODGE_MARGIN    = DODGE_MARGIN_DEF,
   parameter int DODGE_LOOKAHEAD = DODGE_LOOKAHEAD_DEF,
   parameter int DODGE_WAIT      = DODGE_WAIT_DEF
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 pause,
   input  logic [COORD_W-1:0]   pixelX,
   input  logic [COORD_W-1:0]   pixelY,
   input  logic                 enemyDR,
   input  logic                 towerDR,
   input  logic [NUM_SHOTS-1:0] shotDR,
   input  logic [COORD_W-1:0]   enemyTopLeftX,
   input  logic [COORD_W-1:0]   enemyTopLeftY,
   output logic                 changeDirection,
   output logic                 dodgeBullet,
   output logic [NUM_SHOTS-1:0] shotCollision
);

   localparam logic [COOL_W-1:0] WAIT_LOAD = COOL_W'(DODGE_WAIT);

   state_t               state;
   logic                 inZone;
   logic                 towerTerm, zoneTerm;
   logic [NUM_SHOTS-1:0] shotTerm;
   logic                 towerAcc, zoneAcc;
   logic [NUM_SHOTS-1:0] shotAcc;
   logic                 towerRep, zoneRep;
   logic [NUM_SHOTS-1:0] shotRep;
   logic [COOL_W-1:0]    cooldown;
   logic                 reportLive;

   dodge_zone #(
      .ENEMY_W        (ENEMY_W),
      .ENEMY_H        (ENEMY_H),
      .DODGE_MARGIN   (DODGE_MARGIN),
      .DODGE_LOOKAHEAD(DODGE_LOOKAHEAD)
   ) uZone (
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .enemyTopLeftX(enemyTopLeftX),
      .enemyTopLeftY(enemyTopLeftY),
      .inZone       (inZone)
   );

   always_comb begin
      towerTerm = enemyDR & towerDR;
      shotTerm  = {NUM_SHOTS{enemyDR}} & shotDR;
      zoneTerm  = (|shotDR) & inZone;
   end

   always_comb begin
      reportLive      = (state == S_REPORT) && !pause;
      changeDirection = reportLive & towerRep;
      shotCollision   = reportLive ? shotRep : '0;
      dodgeBullet     = reportLive & zoneRep & (cooldown == '0) & (shotRep == '0);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= S_SCAN;
         towerAcc <= 1'b0;
         zoneAcc  <= 1'b0;
         shotAcc  <= '0;
         towerRep <= 1'b0;
         zoneRep  <= 1'b0;
         shotRep  <= '0;
         cooldown <= '0;
      end else begin
         unique case (state)
            S_SCAN: begin
               if (startOfFrame) begin
                  state    <= S_REPORT;
                  towerRep <= towerAcc;
                  zoneRep  <= zoneAcc;
                  shotRep  <= shotAcc;
                  // The frame-start pixel opens the new frame rather than closing the old one.
                  towerAcc <= towerTerm & !pause;
                  zoneAcc  <= zoneTerm & !pause;
                  shotAcc  <= pause ? '0 : shotTerm;
               end else if (!pause) begin
                  towerAcc <= towerAcc | towerTerm;
                  zoneAcc  <= zoneAcc | zoneTerm;
                  shotAcc  <= shotAcc | shotTerm;
               end
            end
            S_REPORT: begin
               if (!pause) begin
                  towerAcc <= towerAcc | towerTerm;
                  zoneAcc  <= zoneAcc | zoneTerm;
                  shotAcc  <= shotAcc | shotTerm;
               end
               if (dodgeBullet) begin
                  cooldown <= WAIT_LOAD;
               end else if (!pause && cooldown != '0) begin
                  cooldown <= cooldown - 1'b1;
               end
               state <= (|shotRep) ? S_DEAD : S_SCAN;
            end
            S_DEAD: begin
               state <= S_DEAD;
            end
            default: begin
               state <= S_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_collision_detect.sv
// Directed self-checking bench for enemy_collision_detect.
module tb_enemy_collision_detect;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic        pause;
   logic [10:0] pixelX, pixelY;
   logic        enemyDR, towerDR;
   logic [2:0]  shotDR;
   logic [10:0] enemyTopLeftX, enemyTopLeftY;
   logic        changeDirection, dodgeBullet;
   logic [2:0]  shotCollision;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   enemy_collision_detect #(
      .ENEMY_W        (32),
      .ENEMY_H        (32),
      .DODGE_MARGIN   (16),
      .DODGE_LOOKAHEAD(64),
      .DODGE_WAIT     (35)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .pause          (pause),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .enemyDR        (enemyDR),
      .towerDR        (towerDR),
      .shotDR         (shotDR),
      .enemyTopLeftX  (enemyTopLeftX),
      .enemyTopLeftY  (enemyTopLeftY),
      .changeDirection(changeDirection),
      .dodgeBullet    (dodgeBullet),
      .shotCollision  (shotCollision)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      enemyDR      = 1'b0;
      towerDR      = 1'b0;
      shotDR       = 3'b000;
      startOfFrame = 1'b0;
      pixelX       = 11'd0;
      pixelY       = 11'd0;
   endtask

   task automatic doReset();
      clearIn();
      pause  = 1'b0;
      resetN = 1'b0;
      cyc();
      cyc();
      resetN = 1'b1;
      cyc();
   endtask

   task automatic drivePix(input logic [10:0] x, input logic [10:0] y,
                           input logic e, input logic t, input logic [2:0] s);
      pixelX  = x;
      pixelY  = y;
      enemyDR = e;
      towerDR = t;
      shotDR  = s;
      cyc();
      enemyDR = 1'b0;
      towerDR = 1'b0;
      shotDR  = 3'b000;
   endtask

   // Leaves the bench sitting in the report cycle.
   task automatic startFrame();
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
   endtask

   task automatic test_reset();
      clearIn();
      pause         = 1'b0;
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      resetN        = 1'b0;
      cyc();
      total++;
      if (changeDirection !== 1'b0) begin
         bad++;
         $display("FAIL reset_cd got=%b want=0", changeDirection);
      end
      total++;
      if (dodgeBullet !== 1'b0) begin
         bad++;
         $display("FAIL reset_db got=%b want=0", dodgeBullet);
      end
      total++;
      if (shotCollision !== 3'b000) begin
         bad++;
         $display("FAIL reset_sc got=%b want=000", shotCollision);
      end
      resetN = 1'b1;
      cyc();
      startFrame();
      total++;
      if ({changeDirection, dodgeBullet, shotCollision} !== 5'b0) begin
         bad++;
         $display("FAIL reset_first_report got=%b want=00000",
                  {changeDirection, dodgeBullet, shotCollision});
      end
      cyc();
   endtask

   task automatic test_shot_hit();
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      drivePix(11'd250, 11'd220, 1'b1, 1'b0, 3'b010);
      cyc();
      startFrame();
      total++;
      if (shotCollision !== 3'b010) begin
         bad++;
         $display("FAIL shot_report got=%b want=010", shotCollision);
      end
      total++;
      if ({changeDirection, dodgeBullet} !== 2'b00) begin
         bad++;
         $display("FAIL shot_report_others got=%b want=00", {changeDirection, dodgeBullet});
      end
      cyc();
      total++;
      if (shotCollision !== 3'b000) begin
         bad++;
         $display("FAIL shot_one_cycle got=%b want=000", shotCollision);
      end
      drivePix(11'd250, 11'd220, 1'b1, 1'b1, 3'b001);
      drivePix(11'd230, 11'd260, 1'b0, 1'b0, 3'b001);
      startFrame();
      total++;
      if ({changeDirection, dodgeBullet, shotCollision} !== 5'b0) begin
         bad++;
         $display("FAIL dead_silent got=%b want=00000",
                  {changeDirection, dodgeBullet, shotCollision});
      end
      cyc();
   endtask

   task automatic test_tower();
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      drivePix(11'd245, 11'd215, 1'b1, 1'b1, 3'b000);
      startFrame();
      total++;
      if (changeDirection !== 1'b1) begin
         bad++;
         $display("FAIL tower_cd got=%b want=1", changeDirection);
      end
      total++;
      if ({dodgeBullet, shotCollision} !== 4'b0) begin
         bad++;
         $display("FAIL tower_others got=%b want=0000", {dodgeBullet, shotCollision});
      end
      cyc();
      total++;
      if (changeDirection !== 1'b0) begin
         bad++;
         $display("FAIL tower_one_cycle got=%b want=0", changeDirection);
      end
   endtask

   task automatic test_dodge_cooldown();
      logic exp;
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      for (int f = 1; f <= 40; f++) begin
         drivePix(11'd230, 11'd260, 1'b0, 1'b0, 3'b001);
         startFrame();
         exp = (f == 1) || (f == 37);
         total++;
         if (dodgeBullet !== exp) begin
            bad++;
            $display("FAIL dodge_frame%0d got=%b want=%b", f, dodgeBullet, exp);
         end
         cyc();
      end
   endtask

   task automatic test_clamp();
      doReset();
      enemyTopLeftX = 11'd5;
      enemyTopLeftY = 11'd210;
      drivePix(11'd53, 11'd250, 1'b0, 1'b0, 3'b001);
      drivePix(11'd100, 11'd241, 1'b0, 1'b0, 3'b001);
      drivePix(11'd40, 11'd306, 1'b0, 1'b0, 3'b001);
      startFrame();
      total++;
      if (dodgeBullet !== 1'b0) begin
         bad++;
         $display("FAIL zone_outside got=%b want=0", dodgeBullet);
      end
      cyc();
      drivePix(11'd0, 11'd250, 1'b0, 1'b0, 3'b001);
      startFrame();
      total++;
      if (dodgeBullet !== 1'b1) begin
         bad++;
         $display("FAIL zone_clamp_x0 got=%b want=1", dodgeBullet);
      end
      cyc();
   endtask

   task automatic test_sof_edge();
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      pixelX        = 11'd245;
      pixelY        = 11'd215;
      enemyDR       = 1'b1;
      towerDR       = 1'b1;
      startOfFrame  = 1'b1;
      cyc();
      clearIn();
      total++;
      if (changeDirection !== 1'b0) begin
         bad++;
         $display("FAIL sof_edge_current got=%b want=0", changeDirection);
      end
      cyc();
      startFrame();
      total++;
      if (changeDirection !== 1'b1) begin
         bad++;
         $display("FAIL sof_edge_next got=%b want=1", changeDirection);
      end
      cyc();
   endtask

   task automatic test_pause();
      logic exp;
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      drivePix(11'd230, 11'd260, 1'b0, 1'b0, 3'b001);
      startFrame();
      total++;
      if (dodgeBullet !== 1'b1) begin
         bad++;
         $display("FAIL pause_prime_dodge got=%b want=1", dodgeBullet);
      end
      cyc();
      pause = 1'b1;
      drivePix(11'd245, 11'd215, 1'b1, 1'b1, 3'b011);
      drivePix(11'd230, 11'd260, 1'b0, 1'b0, 3'b001);
      startFrame();
      total++;
      if ({changeDirection, dodgeBullet, shotCollision} !== 5'b0) begin
         bad++;
         $display("FAIL pause_report got=%b want=00000",
                  {changeDirection, dodgeBullet, shotCollision});
      end
      cyc();
      pause = 1'b0;
      for (int j = 1; j <= 36; j++) begin
         drivePix(11'd230, 11'd260, 1'b0, 1'b0, 3'b001);
         startFrame();
         exp = (j == 36);
         total++;
         if ({changeDirection, dodgeBullet, shotCollision} !== {1'b0, exp, 3'b000}) begin
            bad++;
            $display("FAIL pause_cooldown_frame%0d got=%b want=%b", j,
                     {changeDirection, dodgeBullet, shotCollision}, {1'b0, exp, 3'b000});
         end
         cyc();
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      enemyTopLeftX = 11'd240;
      enemyTopLeftY = 11'd210;
      drivePix(11'd245, 11'd215, 1'b1, 1'b1, 3'b100);
      cyc();
      resetN = 1'b0;
      cyc();
      resetN = 1'b1;
      cyc();
      startFrame();
      total++;
      if ({changeDirection, dodgeBullet, shotCollision} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid_report got=%b want=00000",
                  {changeDirection, dodgeBullet, shotCollision});
      end
      cyc();
      drivePix(11'd245, 11'd215, 1'b1, 1'b1, 3'b000);
      startFrame();
      total++;
      if (changeDirection !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_alive got=%b want=1", changeDirection);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_shot_hit();
      test_tower();
      test_dodge_cooldown();
      test_clamp();
      test_sof_edge();
      test_pause();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enemy_collision_detect.md
ENEMY_COLLISION_DETECT -- requirements
Module: enemy_collision_detect

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
 ENEMY_W, 32, enemy sprite width in pixels
 ENEMY_H, 32, enemy sprite height in pixels
 DODGE_MARGIN, 16, horizontal widening of the dodge zone on each side
 DODGE_LOOKAHEAD, 64, dodge zone depth below the enemy's bottom edge
 DODGE_WAIT, 35, frames between dodge requests
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
 clk  in  1  system clock
 resetN  in  1  reset, asynchronous, active-low
 startOfFrame  in  1  one-cycle frame-start strobe
 pause  in  1  freeze event capture and cooldown
 pixelX, pixelY  in  11 each  current scan pixel
 enemyDR  in  1  enemy sprite drawing request
 towerDR  in  1  tower drawing request
 shotDR  in  3  per-shot drawing requests, bit i = shot i
 enemyTopLeftX, enemyTopLeftY  in  11 each  enemy position
 changeDirection  out  1  tower-overlap report pulse
 dodgeBullet  out  1  incoming-shot report pulse
 shotCollision  out  3  shot-hit report pulse, bit i = shot i

Function
REQ-003 Tower hit term SHALL be enemyDR AND towerDR; shot hit term i SHALL be enemyDR AND shotDR[i].
REQ-004 Zone term SHALL be true when any shotDR bit is set and the pixel lies in the zone. Zone X is enemyTopLeftX-DODGE_MARGIN to enemyTopLeftX+ENEMY_W-1+DODGE_MARGIN, inclusive.
REQ-005 Zone Y is enemyTopLeftY+ENEMY_H to enemyTopLeftY+ENEMY_H+DODGE_LOOKAHEAD-1, inclusive.
REQ-006 Zone arithmetic SHALL use 13-bit signed values; a negative lower X bound SHALL clamp to 0, with no wrap-around.
REQ-007 Per-frame sticky accumulators (towerAcc, shotAcc[2:0], zoneAcc) SHALL OR in the hit and zone terms every cycle in S_SCAN while pause=0.
REQ-008 The FSM SHALL have the states S_SCAN, S_REPORT and S_DEAD.
REQ-009 In S_SCAN with startOfFrame=1: go to S_REPORT; copy the accumulators to the report registers; load each accumulator with that cycle's term, not 0, so that cycle's pixel belongs to the new frame.
REQ-010 S_REPORT SHALL last exactly one clock, which is the cycle after startOfFrame. Outputs are valid only in that cycle and are 0 in all other states and cycles.
REQ-011 In S_REPORT: shotCollision = shot report bits; changeDirection = tower report bit.
REQ-012 In S_REPORT, dodgeBullet = zone report bit AND cooldown==0 AND shot report==0. A shot hit suppresses the dodge.
REQ-013 Accumulation SHALL continue during the S_REPORT cycle.
REQ-014 S_REPORT SHALL go to S_DEAD if any shot report bit is set, and to S_SCAN otherwise.
REQ-015 S_DEAD SHALL drive all outputs to 0, ignore all inputs, and leave only on resetN.
REQ-016 The cooldown counter SHALL be 6 bits wide and load DODGE_WAIT in the cycle dodgeBullet=1.
REQ-017 Otherwise, in each S_REPORT cycle with pause=0, the cooldown counter SHALL decrement, saturating at 0.
REQ-018 While pause=1: accumulators hold, cooldown holds, and the S_REPORT outputs are forced to 0. The FSM still advances, and report registers discarded during pause are lost.
REQ-019 A startOfFrame arriving while in S_REPORT cannot happen legally; if it does, it SHALL be ignored.

Reset
REQ-020 On resetN=0: state=S_SCAN; all accumulators and report registers=0; cooldown=0; changeDirection=0, dodgeBullet=0, shotCollision=3'b000.
REQ-021 Reset mid-frame SHALL discard any partial accumulation; the first report after reset covers only pixels seen after reset.

Structure
REQ-022 Package enemy_collision_pkg SHALL hold the state enum, NUM_SHOTS=3, and the default parameter constants.
REQ-023 One sub-module, dodge_zone, SHALL hold the combinational zone comparison of REQ-004 to REQ-006; all state SHALL stay in the top module.

Verification
REQ-024 Enemy at (240,210). Drive enemyDR and shotDR=3'b010 together at pixel (250,220), then startOfFrame. Expect shotCollision=3'b010 for exactly the next clock, then S_DEAD; all later frames give all outputs 0.
REQ-025 enemyDR and towerDR overlap in one frame. Expect changeDirection=1 for one clock after startOfFrame, and dodgeBullet=0.
REQ-026 shotDR=3'b001 at (230,260), in the zone, over frames 1 to 40. Expect dodgeBullet pulses in frame 1 and frame 37 only.
REQ-027 Enemy X=5. A shot at pixelX=0 inside the Y zone SHALL set dodgeBullet.
REQ-028 A tower overlap occurring only in the startOfFrame cycle SHALL be reported in the following frame, not the current one.
REQ-029 With pause=1, overlapping tower and shot events SHALL give all outputs 0 and keep the cooldown unchanged. Reset asserted mid-frame SHALL clear the pending reports.
